// File: rtl/cpc_bus_pkg.sv
// cpc_bus_pkg: shared types and helpers for the CPC expansion-bus master.
package cpc_bus_pkg;

    typedef enum logic [3:0] {IDLE, REQ, T1, T2, TWI, TW, T3, DONE, ABORT, REL} state_t;

    typedef struct packed {
        logic mreq_b;
        logic ioreq_b;
        logic rd_b;
        logic wr_b;
    } strobe_t;

    localparam strobe_t STB_OFF = '{mreq_b: 1'b1, ioreq_b: 1'b1, rd_b: 1'b1, wr_b: 1'b1};

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpc_bus_master_if.sv
// cpc_bus_master_if: command/response handshake plus Z80 expansion-bus pins.
interface cpc_bus_master_if;
    logic        CMD_VALID, CMD_READY, CMD_WRITE, CMD_IO;
    logic [15:0] CMD_ADDR;
    logic [7:0]  CMD_WDATA;
    logic        RSP_VALID, RSP_TIMEOUT;
    logic [7:0]  RSP_RDATA;
    logic        BUSRQ_B, BUSACK_B, READY;
    logic [15:0] A_OUT;
    logic        A_OE, D_OE;
    logic [7:0]  D_OUT, D_IN;
    logic        MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_IO, CMD_ADDR, CMD_WDATA, BUSACK_B, READY, D_IN,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT, BUSRQ_B, A_OUT, A_OE,
               D_OUT, D_OE, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_IO, CMD_ADDR, CMD_WDATA, BUSACK_B, READY, D_IN,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_TIMEOUT, BUSRQ_B, A_OUT, A_OE,
               D_OUT, D_OE, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B
    );
endinterface

// File: rtl/cpc_bus_master.sv
// cpc_bus_master: requests the CPC bus and runs one Z80-timed memory or IO cycle per command.
module cpc_bus_master
    import cpc_bus_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1024,
    parameter int MAX_WAIT    = 256,
    parameter bit HOLD_BUS    = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET_B,
    cpc_bus_master_if.master  bus
);

    localparam int AW = cnt_w(ACK_TIMEOUT);
    localparam int WW = cnt_w(MAX_WAIT);

    state_t          state, nxt;
    logic [AW-1:0]   ack_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            own, wr, io;
    logic [15:0]     addr;
    logic [7:0]      wdata, rdata;
    strobe_t         stb;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) state <= IDLE;
        else          state <= nxt;
    end

    // own tracks bus ownership so HOLD_BUS can skip REQ on the next command
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            ack_cnt  <= '0;
            wait_cnt <= '0;
            own      <= 1'b0;
            wr       <= 1'b0;
            io       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && bus.CMD_VALID) begin
                wr    <= bus.CMD_WRITE;
                io    <= bus.CMD_IO;
                addr  <= bus.CMD_ADDR;
                wdata <= bus.CMD_WDATA;
            end
            ack_cnt  <= (state == REQ) ? ack_cnt + 1'b1 : '0;
            wait_cnt <= (state == TW) ? wait_cnt + 1'b1 : '0;
            own      <= (state == REQ && !bus.BUSACK_B) || (own && state != REL);
            if (state == T3 && !wr) rdata <= bus.D_IN;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.CMD_VALID) nxt = (HOLD_BUS && own) ? T1 : REQ;
            REQ:     nxt = !bus.BUSACK_B ? T1 : (ack_cnt == AW'(ACK_TIMEOUT - 1)) ? ABORT : REQ;
            T1:      nxt = T2;
            T2:      nxt = io ? TWI : bus.READY ? T3 : TW;
            TWI:     nxt = bus.READY ? T3 : TW;
            TW:      nxt = bus.READY ? T3 : (wait_cnt == WW'(MAX_WAIT - 1)) ? ABORT : TW;
            T3:      nxt = DONE;
            DONE:    nxt = HOLD_BUS ? IDLE : REL;
            ABORT:   nxt = REL;
            REL:     nxt = bus.BUSACK_B ? IDLE : REL;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        stb = (state inside {T2, TWI, TW, T3})
            ? '{mreq_b: io, ioreq_b: !io, rd_b: wr, wr_b: !wr} : STB_OFF;
        bus.CMD_READY   = (state == IDLE);
        bus.RSP_VALID   = (state inside {DONE, ABORT});
        bus.RSP_TIMEOUT = (state == ABORT);
        bus.BUSRQ_B     = !(state == REQ || (own && state != REL));
        bus.A_OE        = (state inside {T1, T2, TWI, TW, T3, DONE});
        bus.D_OE        = wr && (state inside {T1, T2, TWI, TW, T3});
    end

    assign bus.MREQ_B    = stb.mreq_b;
    assign bus.IOREQ_B   = stb.ioreq_b;
    assign bus.RD_B      = stb.rd_b;
    assign bus.WR_B      = stb.wr_b;
    assign bus.M1_B      = 1'b1;
    assign bus.RFSH_B    = 1'b1;
    assign bus.A_OUT     = addr;
    assign bus.D_OUT     = wdata;
    assign bus.RSP_RDATA = rdata;

endmodule

// File: doc/cpc_bus_master.md
Name: cpc_bus_master

Overview:
- Z80-bus initiator for the CPC expansion connector, the opposite end of the memory/IO responder logic in the RAM expansion CPLD.
- Takes single read/write commands on a simple valid/ready interface and requests the bus via BUSRQ_B/BUSACK_B.
- Once it owns the bus, drives one Z80-timed memory or IO cycle (T1/T2/[TW]/T3), honours READY, and returns read data.
- Used for board bring-up, exercising bank-select ports, and DMA-style transfers.

Parameters:
ACK_TIMEOUT, 1024, max CLK cycles in REQ waiting for BUSACK_B low before aborting
MAX_WAIT, 256, max wait states (TW) per cycle before aborting
HOLD_BUS, 0, 1 = keep bus ownership for back-to-back commands

Ports:
CLK  in  1  CPC bus clock (4 MHz); all logic on rising edge
RESET_B  in  1  asynchronous, active-low reset
CMD_VALID  in  1  command present
CMD_READY  out  1  command accepted when VALID&READY
CMD_WRITE  in  1  1=write, 0=read
CMD_IO  in  1  1=IO cycle, 0=memory cycle
CMD_ADDR  in  16  cycle address
CMD_WDATA  in  8  write data
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  8  read data (valid with RSP_VALID, read only)
RSP_TIMEOUT  out  1  1 = aborted (ack or wait timeout), qualified by RSP_VALID
BUSRQ_B  out  1  bus request, active low
BUSACK_B  in  1  bus acknowledge from Z80, active low
READY  in  1  0 = insert wait state
A_OUT  out  16  address drive value
A_OE  out  1  address/control output enable
D_OUT  out  8  data drive value
D_OE  out  1  data output enable
D_IN  in  8  data bus sample
MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B  out  1 each  strobes (valid when A_OE=1)

Behaviour:
- Reset (async, RESET_B=0): state IDLE; BUSRQ_B=1; all strobes=1; A_OE=D_OE=0; A_OUT=0; D_OUT=0; RSP_*=0; counters 0. Reset mid-cycle releases the bus immediately.
- M1_B and RFSH_B are always 1; strobes are 1 in every state not listed below.
- IDLE: CMD_READY=1. On accept, capture command; go REQ. If HOLD_BUS=1 and the bus is still owned, go T1 directly.
- REQ: BUSRQ_B=0; ack counter increments each cycle.
  - BUSACK_B==0 sampled: go T1.
  - Else, counter==ACK_TIMEOUT-1: go ABORT.
- T1: A_OE=1, A_OUT=addr. D_OE=1, D_OUT=wdata for writes.
- T2: MREQ_B=0 (mem) or IOREQ_B=0 (io); RD_B=0 (read) or WR_B=0 (write).
  - IO: go TWI.
  - Mem, READY=1: go T3.
  - Mem, READY=0: go TW.
- TWI: automatic IO wait state, strobes held. READY=1: T3; else TW.
- TW: strobes held; wait counter increments.
  - READY=1: go T3.
  - Counter==MAX_WAIT-1: go ABORT.
- T3: strobes held; D_IN registered into RSP_RDATA on the edge leaving T3 (reads only; writes leave RSP_RDATA unchanged). Go DONE.
- DONE: strobes=1, A_OE held 1 for hold time; RSP_VALID=1, RSP_TIMEOUT=0.
  - HOLD_BUS=1: go IDLE with the bus still owned.
  - Else: go REL.
- ABORT: RSP_VALID=1, RSP_TIMEOUT=1; strobes=1; go REL.
- REL: A_OE=D_OE=0, BUSRQ_B=1; stay until BUSACK_B==1, then go IDLE.
- Counters clear on entry to REQ and to T1.
- Latency, no waits, bus pre-owned: mem = 4 cycles accept→RSP_VALID (T1,T2,T3,DONE); IO = 5.
- CMD_READY=0 in every state except IDLE; CMD_VALID elsewhere is ignored and must be held by the source.
- BUSACK_B or READY are sampled only in the states named; a BUSACK_B deassertion mid-cycle is a protocol error, not handled.

Decomposition:
- Package cpc_bus_pkg holds:
  - state enum (IDLE, REQ, T1, T2, TWI, TW, T3, DONE, ABORT, REL)
  - strobe-inactive constant
  - counter width functions, clog2 of ACK_TIMEOUT and MAX_WAIT
- Single module, no sub-module; the timeout counters are inline.

Test Plan:
- Mem read 0x4000, BUSACK_B low 3 cycles after BUSRQ_B, READY=1, D_IN=0xA5 in T3 → MREQ_B/RD_B low exactly T2–T3; RSP_RDATA=0xA5; RSP_TIMEOUT=0.
- IO write 0x7F00 data 0xC4 (bank select), READY=1 → IOREQ_B/WR_B low for 3 cycles (T2,TWI,T3); D_OE=1 with D_OUT=0xC4 from T1 to T3.
- Mem write with READY=0 for 5 cycles in T2/TW → exactly 5 TW cycles; strobes held throughout; one RSP_VALID pulse.
- BUSACK_B held high, ACK_TIMEOUT=16 → BUSRQ_B low 16 cycles; RSP_VALID with RSP_TIMEOUT=1; BUSRQ_B returns 1; A_OE never asserted.
- RESET_B pulsed low during TW → same-cycle BUSRQ_B=1, strobes=1, A_OE=D_OE=0; no RSP_VALID; next command completes normally.
- HOLD_BUS=1, two back-to-back reads at 0x0000 and 0x0001 → BUSRQ_B stays 0 between commands; second cycle starts T1 the cycle after acceptance, with no REQ state.
